// File: rtl/pip20_cla.sv
// 20-bit adder pipelined as five registered 4-bit carry-lookahead groups.
// Operands are captured once, skewed to their group, and sums realigned for a fixed 7-cycle latency.
module pip20_cla (
    input  logic [19:0] a,
    input  logic [19:0] b,
    input  logic        cin,
    input  logic        clk,
    output logic [19:0] sum,
    output logic        cout,
    input  logic        rst
);

    logic        r_cin;
    logic [4:0]  w_grp_cin;
    logic [4:0]  w_grp_cout;
    logic [19:0] w_sum_al;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cin <= 1'b0;
        end else begin
            r_cin <= cin;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_grp
            // Entry 0 is the input capture stage; entry gi feeds this group's lookahead.
            logic [3:0] r_a_sk  [0:gi];
            logic [3:0] r_b_sk  [0:gi];
            // Entry 0 holds the fresh nibble; the last entry lines up with the other groups.
            logic [3:0] r_s_dly [0:4-gi];
            logic       r_cout;
            logic [3:0] w_p;
            logic [3:0] w_g;
            logic [4:0] w_c;

            assign w_p    = r_a_sk[gi] ^ r_b_sk[gi];
            assign w_g    = r_a_sk[gi] & r_b_sk[gi];
            assign w_c[0] = w_grp_cin[gi];
            assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
            assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
            assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                          | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
            assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                          | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                          | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i <= gi; i++) begin
                        r_a_sk[i] <= '0;
                        r_b_sk[i] <= '0;
                    end
                    for (int i = 0; i <= 4 - gi; i++) begin
                        r_s_dly[i] <= '0;
                    end
                    r_cout <= 1'b0;
                end else begin
                    r_a_sk[0] <= a[4*gi +: 4];
                    r_b_sk[0] <= b[4*gi +: 4];
                    for (int i = 1; i <= gi; i++) begin
                        r_a_sk[i] <= r_a_sk[i-1];
                        r_b_sk[i] <= r_b_sk[i-1];
                    end
                    r_s_dly[0] <= w_p ^ w_c[3:0];
                    for (int i = 1; i <= 4 - gi; i++) begin
                        r_s_dly[i] <= r_s_dly[i-1];
                    end
                    r_cout <= w_c[4];
                end
            end

            assign w_grp_cout[gi]        = r_cout;
            assign w_sum_al[4*gi +: 4]   = r_s_dly[4-gi];

            if (gi == 0) begin : g_first
                assign w_grp_cin[gi] = r_cin;
            end else begin : g_next
                assign w_grp_cin[gi] = w_grp_cout[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= w_sum_al;
            cout <= w_grp_cout[4];
        end
    end

endmodule

// File: tb/tb_pip20_cla.sv
// Self-checking bench for pip20_cla: directed vector table, streaming and reset sequences, random traffic.
module tb_pip20_cla;

    logic [19:0] a   = '0;
    logic [19:0] b   = '0;
    logic        cin = 1'b0;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;

    // Expected {cout,sum} for operands applied on each of the last cycles, oldest first.
    logic [20:0] exp_q [$];

    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic        cin;
        logic [19:0] sum;
        logic        cout;
    } vec_t;

    vec_t single_tab [4];
    vec_t stream_tab [4];

    pip20_cla dut (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .clk  (clk),
        .sum  (sum),
        .cout (cout),
        .rst  (rst)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] ref_add(input logic [19:0] x, input logic [19:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {20'd0, c};
    endfunction

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got cout=%0b sum=0x%05h, want cout=%0b sum=0x%05h",
                     name, act[20], act[19:0], req[20], req[19:0]);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(21'd0);
    endtask

    // Apply one operand set, clock once, compare against the model's output for that edge.
    task automatic step(input logic [19:0] x, input logic [19:0] y, input logic c, input string name);
        a = x; b = y; cin = c;
        exp_q.push_back(ref_add(x, y, c));
        @(posedge clk);
        #1;
        chk(name, {cout, sum}, exp_q.pop_front());
        $display("txn %-8s a=0x%05h b=0x%05h cin=%0b -> cout=%0b sum=0x%05h", name, x, y, c, cout, sum);
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b1;
        #1;
        chk("rst_imm", {cout, sum}, 21'd0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", {cout, sum}, 21'd0);
        end
        rst = 1'b0;
        model_flush();
    endtask

    initial begin
        single_tab[0] = '{20'h00380, 20'h00070, 1'b0, 20'h003F0, 1'b0};
        single_tab[1] = '{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1};
        single_tab[2] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1};
        single_tab[3] = '{20'h00000, 20'h00000, 1'b1, 20'h00001, 1'b0};
        stream_tab[0] = '{20'h0000F, 20'h00001, 1'b0, 20'h00010, 1'b0};
        stream_tab[1] = '{20'h000F0, 20'h00010, 1'b0, 20'h00100, 1'b0};
        stream_tab[2] = '{20'h12345, 20'h6789A, 1'b0, 20'h79BDF, 1'b0};
        stream_tab[3] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1};

        // Reset asserted away from any clock edge with all-ones operands.
        a = 20'hFFFFF; b = 20'hFFFFF; cin = 1'b1;
        #2;
        hold_reset(3);

        // Isolated operands surrounded by zeros; the 7th edge must show the table value.
        for (int t = 0; t < 4; t++) begin
            step(single_tab[t].a, single_tab[t].b, single_tab[t].cin, "single");
            for (int k = 1; k < 7; k++) step(20'd0, 20'd0, 1'b0, "lat_pre");
            chk("single_tab", {cout, sum}, {single_tab[t].cout, single_tab[t].sum});
            step(20'd0, 20'd0, 1'b0, "lat_post");
        end

        // Back-to-back stream: four results on consecutive edges starting at edge 7.
        for (int t = 0; t < 4; t++) step(stream_tab[t].a, stream_tab[t].b, stream_tab[t].cin, "stream");
        for (int k = 4; k < 6; k++) step(20'd0, 20'd0, 1'b0, "str_gap");
        for (int t = 0; t < 4; t++) begin
            step(20'd0, 20'd0, 1'b0, "str_out");
            chk("stream_tab", {cout, sum}, {stream_tab[t].cout, stream_tab[t].sum});
        end

        // Reset three cycles into the stream: nothing presented before it may emerge.
        for (int t = 0; t < 3; t++) step(stream_tab[t].a, stream_tab[t].b, stream_tab[t].cin, "pre_rst");
        a = stream_tab[3].a; b = stream_tab[3].b; cin = stream_tab[3].cin;
        hold_reset(2);
        step(single_tab[1].a, single_tab[1].b, single_tab[1].cin, "post_rst");
        for (int k = 1; k < 7; k++) step(20'd0, 20'd0, 1'b0, "post_gap");
        chk("post_rst_val", {cout, sum}, {single_tab[1].cout, single_tab[1].sum});
        for (int k = 0; k < 3; k++) step(20'd0, 20'd0, 1'b0, "post_tail");

        // Random traffic, including operands biased toward long carry chains.
        for (int n = 0; n < 300; n++) begin
            logic [19:0] ra, rb;
            ra = 20'($urandom);
            rb = 20'($urandom);
            if (n % 5 == 0) rb = ~ra;
            step(ra, rb, 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got simulation still running, want finished");
        $fatal(1, "timeout");
    end

endmodule
